// File: rtl/b_route_id_fifo_pkg.sv
// Shared interconnect package: ID-tracker width constants and one-hot/index helpers,
// used by both the B-side and the R-side routing trackers.
package b_route_id_fifo_pkg;

    localparam int DEF_NUM_MASTERS = 16;
    localparam int DEF_DEPTH       = 4;
    localparam int MID_W           = $clog2(DEF_NUM_MASTERS);
    localparam int CNT_W           = $clog2(DEF_DEPTH) + 1;

    // Helpers work on the widest supported bus; callers extend and truncate with casts.
    localparam int MAX_MASTERS = 64;
    localparam int MAX_MID_W   = 6;

    // Highest set bit wins, matching the dispatcher's multi-hot resolution; zero maps to 0.
    function automatic logic [MAX_MID_W-1:0] onehot_to_idx_hi(input logic [MAX_MASTERS-1:0] vec);
        logic [MAX_MID_W-1:0] idx;
        idx = {MAX_MID_W{1'b0}};
        for (int i = 0; i < MAX_MASTERS; i++) begin
            idx = vec[i] ? i[MAX_MID_W-1:0] : idx;
        end
        return idx;
    endfunction

    function automatic logic [MAX_MASTERS-1:0] idx_to_onehot(input logic [MAX_MID_W-1:0] idx);
        logic [MAX_MASTERS-1:0] vec;
        vec      = {MAX_MASTERS{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/b_route_id_fifo_if.sv
// Handshake and status bundle between the AW grant logic, the B dispatcher and the
// per-slave write-response routing tracker.
interface b_route_id_fifo_if
    import b_route_id_fifo_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int DEPTH       = DEF_DEPTH
);

    logic [NUM_MASTERS-1:0]   aw_grant_i;
    logic                     aw_hs_i;
    logic                     b_hs_i;
    logic [NUM_MASTERS-1:0]   Master_ID_Selected_o;
    logic                     id_valid_o;
    logic                     full_o;
    logic [$clog2(DEPTH):0]   count_o;
    logic                     orphan_b_o;
    logic                     drop_aw_o;

    modport slave (
        input  aw_grant_i,
        input  aw_hs_i,
        input  b_hs_i,
        output Master_ID_Selected_o,
        output id_valid_o,
        output full_o,
        output count_o,
        output orphan_b_o,
        output drop_aw_o
    );

    modport master (
        output aw_grant_i,
        output aw_hs_i,
        output b_hs_i,
        input  Master_ID_Selected_o,
        input  id_valid_o,
        input  full_o,
        input  count_o,
        input  orphan_b_o,
        input  drop_aw_o
    );

endinterface

// File: rtl/b_route_id_fifo_id_ring_buf.sv
// Generic DEPTH x WIDTH circular buffer of master indices, shared by the B- and R-side
// trackers. Push while full is accepted only when a pop frees a slot in the same cycle.
module id_ring_buf
    import b_route_id_fifo_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = MID_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1'b1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic             push_s;
    logic             pop_s;

    assign full_o    = (count_r == FULL_CNT);
    assign empty_o   = (count_r == {CW{1'b0}});
    assign count_o   = count_r;
    assign rd_data_o = mem_r[rd_ptr_r];

    // Qualify the requests and work out the next occupancy.
    always_comb begin
        pop_s  = pop_i & ~empty_o;
        push_s = push_i & (~full_o | pop_s);
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and occupancy registers; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
        end
    end

    // Entry storage; contents are meaningless outside the occupied window, so no reset.
    always_ff @(posedge clk) begin
        if (rst_n && push_s) begin
            mem_r[wr_ptr_r] <= wr_data_i;
        end
    end

endmodule

// File: rtl/b_route_id_fifo.sv
// Per-slave write-response routing tracker: remembers the owner of each accepted AW in
// order and presents the oldest owner one-hot to the B dispatcher until its B retires.
module b_route_id_fifo
    import b_route_id_fifo_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int DEPTH       = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    b_route_id_fifo_if.slave b_if
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int CW    = $clog2(DEPTH) + 1;

    logic [IDX_W-1:0] push_idx_s;
    logic [IDX_W-1:0] head_idx_s;
    logic [CW-1:0]    count_s;
    logic             full_s;
    logic             empty_s;
    logic             pop_s;
    logic             orphan_r;
    logic             drop_r;

    id_ring_buf #(
        .DEPTH (DEPTH),
        .WIDTH (IDX_W)
    ) u_ring (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (b_if.aw_hs_i),
        .pop_i     (b_if.b_hs_i),
        .wr_data_i (push_idx_s),
        .rd_data_o (head_idx_s),
        .count_o   (count_s),
        .full_o    (full_s),
        .empty_o   (empty_s)
    );

    // Encode the grant on entry and decode the head back to one-hot for the dispatcher.
    always_comb begin
        push_idx_s = IDX_W'(onehot_to_idx_hi(MAX_MASTERS'(b_if.aw_grant_i)));
        pop_s      = b_if.b_hs_i & ~empty_s;
        if (empty_s) begin
            b_if.Master_ID_Selected_o = {NUM_MASTERS{1'b0}};
        end else begin
            b_if.Master_ID_Selected_o = NUM_MASTERS'(idx_to_onehot(MAX_MID_W'(head_idx_s)));
        end
        b_if.id_valid_o = ~empty_s;
        b_if.full_o     = full_s;
        b_if.count_o    = count_s;
        b_if.orphan_b_o = orphan_r;
        b_if.drop_aw_o  = drop_r;
    end

    // Protocol-error pulses, one cycle after the offending handshake; a pop frees the slot
    // for a same-cycle push, so that case is not a drop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            orphan_r <= 1'b0;
            drop_r   <= 1'b0;
        end else begin
            orphan_r <= b_if.b_hs_i & empty_s;
            drop_r   <= b_if.aw_hs_i & full_s & ~pop_s;
        end
    end

endmodule

// File: tb/tb_b_route_id_fifo.sv
// Scoreboard bench for b_route_id_fifo: a queue-of-owners reference model, directed
// scenarios followed by randomized AW/B traffic with occasional resets.
module tb_b_route_id_fifo;
    import b_route_id_fifo_pkg::*;

    localparam int NM = 16;
    localparam int DP = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    b_route_id_fifo_if #(.NUM_MASTERS(NM), .DEPTH(DP)) bus ();

    b_route_id_fifo #(.NUM_MASTERS(NM), .DEPTH(DP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .b_if  (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int q[$];
    bit exp_orphan = 1'b0;
    bit exp_drop   = 1'b0;
    bit mon_en     = 1'b0;
    bit do_pop;
    bit do_push;
    logic [NM-1:0] exp_sel;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int hi_idx(input logic [NM-1:0] g);
        for (int i = NM - 1; i >= 0; i--) begin
            if (g[i]) return i;
        end
        return 0;
    endfunction

    // Drive one cycle of inputs, then advance the reference model at the clock edge.
    task automatic cyc(input bit aw, input logic [NM-1:0] g, input bit b);
        bus.aw_hs_i    = aw;
        bus.aw_grant_i = g;
        bus.b_hs_i     = b;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            exp_orphan = 1'b0;
            exp_drop   = 1'b0;
        end else begin
            do_pop     = b && (q.size() > 0);
            do_push    = aw && ((q.size() < DP) || do_pop);
            exp_orphan = b && (q.size() == 0);
            exp_drop   = aw && (q.size() == DP) && !do_pop;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(hi_idx(g));
        end
        #1;
    endtask

    function automatic logic [NM-1:0] oh(input int m);
        logic [NM-1:0] v;
        v = '0;
        v[m] = 1'b1;
        return v;
    endfunction

    // Monitor: compares every presented output against the model on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                exp_sel = (q.size() > 0) ? oh(q[0]) : '0;
                chk("count", 64'(bus.count_o), 64'(q.size()));
                chk("id_valid", 64'(bus.id_valid_o), 64'(q.size() > 0));
                chk("full", 64'(bus.full_o), 64'(q.size() == DP));
                chk("orphan", 64'(bus.orphan_b_o), 64'(exp_orphan));
                chk("drop", 64'(bus.drop_aw_o), 64'(exp_drop));
                if (bus.id_valid_o) chk("head_sel", 64'(bus.Master_ID_Selected_o), 64'(exp_sel));
                else chk("idle_sel", 64'(bus.Master_ID_Selected_o), 64'd0);
            end
        end
    end

    initial begin
        int mode;
        int bp;
        bit aw;
        bit b;
        logic [NM-1:0] g;

        bus.aw_hs_i    = 1'b0;
        bus.aw_grant_i = '0;
        bus.b_hs_i     = 1'b0;
        rst_n = 1'b0;
        cyc(1'b0, '0, 1'b0);
        mon_en = 1'b1;
        cyc(1'b1, 16'h0040, 1'b1);
        chk("rst_sel", 64'(bus.Master_ID_Selected_o), 64'd0);
        chk("rst_cnt", 64'(bus.count_o), 64'd0);
        rst_n = 1'b1;

        cyc(1'b1, 16'h0020, 1'b0);
        chk("first_sel", 64'(bus.Master_ID_Selected_o), 64'h0020);
        chk("first_cnt", 64'(bus.count_o), 64'd1);
        cyc(1'b0, '0, 1'b1);
        chk("first_pop", 64'(bus.Master_ID_Selected_o), 64'd0);

        cyc(1'b1, oh(3), 1'b0);
        cyc(1'b1, oh(7), 1'b0);
        cyc(1'b1, oh(12), 1'b0);
        chk("ord0", 64'(bus.Master_ID_Selected_o), 64'h0008);
        cyc(1'b0, '0, 1'b1);
        chk("ord1", 64'(bus.Master_ID_Selected_o), 64'h0080);
        cyc(1'b0, '0, 1'b1);
        chk("ord2", 64'(bus.Master_ID_Selected_o), 64'h1000);
        cyc(1'b0, '0, 1'b1);
        chk("ord3", 64'(bus.Master_ID_Selected_o), 64'd0);

        cyc(1'b1, oh(1), 1'b0);
        cyc(1'b1, oh(2), 1'b0);
        cyc(1'b1, oh(4), 1'b0);
        cyc(1'b1, oh(5), 1'b0);
        chk("fill_full", 64'(bus.full_o), 64'd1);
        chk("fill_cnt", 64'(bus.count_o), 64'd4);
        cyc(1'b1, oh(6), 1'b0);
        chk("drop_pulse", 64'(bus.drop_aw_o), 64'd1);
        chk("drop_cnt", 64'(bus.count_o), 64'd4);
        cyc(1'b0, '0, 1'b0);
        chk("drop_end", 64'(bus.drop_aw_o), 64'd0);
        cyc(1'b1, oh(9), 1'b1);
        chk("pp_cnt", 64'(bus.count_o), 64'd4);
        chk("pp_nodrop", 64'(bus.drop_aw_o), 64'd0);
        chk("wrap0", 64'(bus.Master_ID_Selected_o), 64'h0004);
        cyc(1'b0, '0, 1'b1);
        chk("wrap1", 64'(bus.Master_ID_Selected_o), 64'h0010);
        cyc(1'b0, '0, 1'b1);
        chk("wrap2", 64'(bus.Master_ID_Selected_o), 64'h0020);
        cyc(1'b0, '0, 1'b1);
        chk("wrap3", 64'(bus.Master_ID_Selected_o), 64'h0200);
        cyc(1'b0, '0, 1'b1);
        chk("wrap_empty", 64'(bus.id_valid_o), 64'd0);

        cyc(1'b0, '0, 1'b1);
        chk("orphan_pulse", 64'(bus.orphan_b_o), 64'd1);
        chk("orphan_cnt", 64'(bus.count_o), 64'd0);
        cyc(1'b0, '0, 1'b0);
        chk("orphan_end", 64'(bus.orphan_b_o), 64'd0);
        cyc(1'b1, oh(2), 1'b1);
        chk("orphan_push_cnt", 64'(bus.count_o), 64'd1);
        chk("orphan_push_sel", 64'(bus.Master_ID_Selected_o), 64'h0004);
        cyc(1'b0, '0, 1'b1);

        cyc(1'b1, 16'h0003, 1'b0);
        chk("multihot", 64'(bus.Master_ID_Selected_o), 64'h0002);
        cyc(1'b0, '0, 1'b1);

        cyc(1'b1, oh(3), 1'b0);
        cyc(1'b1, oh(4), 1'b0);
        cyc(1'b1, oh(5), 1'b0);
        rst_n = 1'b0;
        cyc(1'b1, oh(5), 1'b1);
        chk("midrst_sel", 64'(bus.Master_ID_Selected_o), 64'd0);
        chk("midrst_valid", 64'(bus.id_valid_o), 64'd0);
        chk("midrst_cnt", 64'(bus.count_o), 64'd0);
        rst_n = 1'b1;
        cyc(1'b1, oh(0), 1'b0);
        chk("post_rst_sel", 64'(bus.Master_ID_Selected_o), 64'h0001);

        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
            bp    = ((n / 300) % 2 == 1) ? 30 : 70;
            mode  = $urandom_range(0, 9);
            if (mode < 7) g = oh($urandom_range(0, NM - 1));
            else if (mode < 9) g = NM'($urandom);
            else g = '0;
            aw = ($urandom_range(0, 99) < 100 - bp);
            b  = ($urandom_range(0, 99) < bp);
            cyc(aw, g, b);
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
